// File: rtl/fpga_top.sv
// 4x4 island-style fabric: routing blocks, 3x3 switch meshes, 2-input LUT logic blocks, tri-state pads.
// Configuration is static and acts combinationally; only the optional LB registers are clocked.
module fpga_top (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [899:0]  brbselect,
    input  logic [1727:0] bsbselect,
    input  logic [79:0]   lbselect,
    input  logic [29:0]   leftioselect,
    input  logic [29:0]   rightioselect,
    input  logic [29:0]   topioselect,
    input  logic [29:0]   bottomioselect,
    inout  wire  [4:0]    left,
    inout  wire  [4:0]    right,
    inout  wire  [4:0]    top,
    inout  wire  [4:0]    bottom
);

    // Flat net numbering: wires, edge terminals, then bsb-internal mesh nets.
    localparam int NNETS = 372;
    localparam int VW_B  = 0;
    localparam int HW_B  = 60;
    localparam int BOT_B = 120;
    localparam int TOP_B = 135;
    localparam int LFT_B = 150;
    localparam int RGT_B = 165;
    localparam int BH_B  = 180;
    localparam int BV_B  = 276;
    localparam int ITER  = NNETS + 1;

    localparam int T_N = 0;
    localparam int T_E = 1;
    localparam int T_S = 2;
    localparam int T_W = 3;
    localparam int SW_A [6] = '{T_W, T_N, T_S, T_S, T_N, T_E};
    localparam int SW_B [6] = '{T_E, T_W, T_W, T_N, T_E, T_S};
    localparam int SIDE_B [4] = '{LFT_B, RGT_B, TOP_B, BOT_B};

    typedef logic [8:0] nid_t;

    function automatic nid_t vw_id(input int r, input int c, input int t);
        return nid_t'(VW_B + (r * 5 + c) * 3 + t);
    endfunction

    function automatic nid_t hw_id(input int r, input int c, input int t);
        return nid_t'(HW_B + (r * 4 + c) * 3 + t);
    endfunction

    function automatic nid_t bh_id(input int r, input int c, input int i, input int j);
        return nid_t'(BH_B + ((r * 4 + c) * 3 + i) * 2 + j);
    endfunction

    function automatic nid_t bv_id(input int r, input int c, input int i, input int j);
        return nid_t'(BV_B + ((r * 4 + c) * 2 + i) * 3 + j);
    endfunction

    function automatic nid_t brb_net(input int r, input int c, input int t, input int k);
        case (k)
            T_N:     return (r < 4) ? vw_id(r, c, t)     : nid_t'(TOP_B + c * 3 + t);
            T_S:     return (r > 0) ? vw_id(r - 1, c, t) : nid_t'(BOT_B + c * 3 + t);
            T_E:     return (c < 4) ? hw_id(r, c, t)     : nid_t'(RGT_B + r * 3 + t);
            default: return (c > 0) ? hw_id(r, c - 1, t) : nid_t'(LFT_B + r * 3 + t);
        endcase
    endfunction

    function automatic nid_t bsb_net(input int r, input int c, input int i, input int j, input int k);
        case (k)
            T_N:     return (i == 2) ? hw_id(r + 1, c, j) : bv_id(r, c, i, j);
            T_S:     return (i == 0) ? hw_id(r, c, j)     : bv_id(r, c, i - 1, j);
            T_E:     return (j == 2) ? vw_id(r, c + 1, i) : bh_id(r, c, i, j);
            default: return (j == 0) ? vw_id(r, c, i)     : bh_id(r, c, i, j - 1);
        endcase
    endfunction

    function automatic nid_t pad_id(input int s, input int i, input int l);
        return nid_t'(SIDE_B[s] + i * 3 + l);
    endfunction

    // Contributions one switch element makes to its four terminals.
    function automatic logic [3:0] se_drive(input logic [11:0] cfg, input logic [3:0] term);
        logic [3:0] d;
        d = '0;
        for (int s = 0; s < 6; s++) begin
            case (cfg[2 * s +: 2])
                2'b10:   d[2'(SW_B[s])] = d[2'(SW_B[s])] | term[2'(SW_A[s])];
                2'b01:   d[2'(SW_A[s])] = d[2'(SW_A[s])] | term[2'(SW_B[s])];
                default: ;
            endcase
        end
        return d;
    endfunction

    logic [NNETS-1:0] pad_src;
    logic [NNETS-1:0] cur;
    logic [NNETS-1:0] nxt;
    logic [3:0]       se_t;
    logic [3:0]       se_d;
    logic [1:0]       lb_in;
    logic [1:0]       io_code_i;
    logic [1:0]       io_code_o;
    logic [15:0]      lb_d;
    logic [15:0]      lb_q;
    logic [29:0]      iosel  [4];
    logic [4:0]       pad_i  [4];
    logic [4:0]       pad_o  [4];
    logic [4:0]       pad_oe [4];

    assign iosel[0] = leftioselect;
    assign iosel[1] = rightioselect;
    assign iosel[2] = topioselect;
    assign iosel[3] = bottomioselect;
    assign pad_i[0] = left;
    assign pad_i[1] = right;
    assign pad_i[2] = top;
    assign pad_i[3] = bottom;

    always_comb begin : pad_in_c
        pad_src   = '0;
        io_code_i = '0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 5; i++) begin
                for (int l = 0; l < 3; l++) begin
                    io_code_i = iosel[2'(s)][5'(i * 6 + l * 2) +: 2];
                    if (io_code_i == 2'b10 && pad_i[2'(s)][3'(i)] == 1'b1) begin
                        pad_src[pad_id(s, i, l)] = 1'b1;
                    end
                end
            end
        end
    end

    // Wired-OR fabric evaluated as a bounded relaxation: every pass pushes values one net further,
    // so with an acyclic configuration the result is exact once the pass count exceeds the net count.
    always_comb begin : fabric_c
        cur   = '0;
        nxt   = '0;
        se_t  = '0;
        se_d  = '0;
        lb_in = '0;
        lb_d  = '0;
        for (int it = 0; it < ITER; it++) begin
            nxt = pad_src;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    lb_in = {cur[bv_id(r, c, 0, 1)], cur[bh_id(r, c, 1, 0)]};
                    lb_d[4'(r * 4 + c)] = lbselect[7'(r * 20 + c * 5) + 7'(lb_in)];
                    if (lbselect[7'(r * 20 + c * 5 + 4)] ? lb_q[4'(r * 4 + c)] : lb_d[4'(r * 4 + c)]) begin
                        nxt[bv_id(r, c, 1, 1)] = 1'b1;
                    end
                end
            end
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    for (int t = 0; t < 3; t++) begin
                        for (int k = 0; k < 4; k++) se_t[2'(k)] = cur[brb_net(r, c, t, k)];
                        se_d = se_drive(brbselect[10'(r * 180 + c * 36 + t * 12) +: 12], se_t);
                        for (int k = 0; k < 4; k++) begin
                            if (se_d[2'(k)]) nxt[brb_net(r, c, t, k)] = 1'b1;
                        end
                    end
                end
            end
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            for (int k = 0; k < 4; k++) se_t[2'(k)] = cur[bsb_net(r, c, i, j, k)];
                            se_d = se_drive(bsbselect[11'(r * 432 + c * 108 + i * 36 + j * 12) +: 12], se_t);
                            for (int k = 0; k < 4; k++) begin
                                if (se_d[2'(k)]) nxt[bsb_net(r, c, i, j, k)] = 1'b1;
                            end
                        end
                    end
                end
            end
            cur = nxt;
        end
    end

    always_comb begin : pad_out_c
        io_code_o = '0;
        for (int s = 0; s < 4; s++) begin
            pad_o[2'(s)]  = '0;
            pad_oe[2'(s)] = '0;
        end
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 5; i++) begin
                for (int l = 0; l < 3; l++) begin
                    io_code_o = iosel[2'(s)][5'(i * 6 + l * 2) +: 2];
                    if (io_code_o == 2'b01) begin
                        pad_oe[2'(s)][3'(i)] = 1'b1;
                        pad_o[2'(s)][3'(i)]  = pad_o[2'(s)][3'(i)] | cur[pad_id(s, i, l)];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_q <= '0;
        end else begin
            lb_q <= lb_d;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_pad
        assign left[g]   = pad_oe[0][g] ? pad_o[0][g] : 1'bz;
        assign right[g]  = pad_oe[1][g] ? pad_o[1][g] : 1'bz;
        assign top[g]    = pad_oe[2][g] ? pad_o[2][g] : 1'bz;
        assign bottom[g] = pad_oe[3][g] ? pad_o[3][g] : 1'bz;
    end

endmodule

// File: tb/tb_fpga_top.sv
// Directed bench for fpga_top: pass-through, LUT XOR/AND (comb and registered), wired-OR, switch-off codes, reset.
module tb_fpga_top;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [899:0]  brbsel;
    logic [1727:0] bsbsel;
    logic [79:0]   lbsel;
    logic [29:0]   lio, rio, tio, bio;
    logic [4:0]    bot_drv;
    tri1  [4:0]    left_p, right_p, top_p;
    wire  [4:0]    bottom_p;

    assign bottom_p = bot_drv;

    fpga_top dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .brbselect      (brbsel),
        .bsbselect      (bsbsel),
        .lbselect       (lbsel),
        .leftioselect   (lio),
        .rightioselect  (rio),
        .topioselect    (tio),
        .bottomioselect (bio),
        .left           (left_p),
        .right          (right_p),
        .top            (top_p),
        .bottom         (bottom_p)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic set_brb(input int r, input int c, input int t, input int sel, input logic [1:0] code);
        brbsel[r * 180 + c * 36 + t * 12 + sel * 2 +: 2] = code;
    endtask

    task automatic set_bsb(input int r, input int c, input int i, input int j, input int sel, input logic [1:0] code);
        bsbsel[r * 432 + c * 108 + i * 36 + j * 12 + sel * 2 +: 2] = code;
    endtask

    // side: 0 left, 1 right, 2 top, 3 bottom
    task automatic set_io(input int side, input int i, input int l, input logic [1:0] code);
        case (side)
            0:       lio[i * 6 + l * 2 +: 2] = code;
            1:       rio[i * 6 + l * 2 +: 2] = code;
            2:       tio[i * 6 + l * 2 +: 2] = code;
            default: bio[i * 6 + l * 2 +: 2] = code;
        endcase
    endtask

    task automatic set_lb(input int r, input int c, input logic [3:0] truth, input logic sync);
        lbsel[r * 20 + c * 5 +: 4] = truth;
        lbsel[r * 20 + c * 5 + 4]  = sync;
    endtask

    // 0 all off, 1 pass-through, 2 XOR comb, 3 wired-OR, 4 break with code 11,
    // 5 top pad code 11, 6 AND registered, 7 break with code 00
    task automatic load_cfg(input int id);
        brbsel = '0; bsbsel = '0; lbsel = '0;
        lio = '0; rio = '0; tio = '0; bio = '0;
        case (id)
            1, 3, 4, 5, 7: begin
                set_io(3, 0, 0, 2'b10);
                for (int r = 0; r < 5; r++) set_brb(r, 0, 0, 3, 2'b10);
                set_io(2, 0, 0, 2'b01);
                if (id == 3) begin
                    set_io(3, 1, 0, 2'b10);
                    set_brb(0, 1, 0, 2, 2'b10);
                    set_brb(0, 0, 0, 4, 2'b01);
                end
                if (id == 4) set_brb(2, 0, 0, 3, 2'b11);
                if (id == 7) set_brb(2, 0, 0, 3, 2'b00);
                if (id == 5) set_io(2, 0, 0, 2'b11);
            end
            2, 6: begin
                set_io(3, 0, 1, 2'b10);
                set_brb(0, 0, 1, 3, 2'b10);
                set_bsb(0, 0, 1, 0, 0, 2'b10);
                set_io(3, 1, 1, 2'b10);
                set_brb(0, 1, 1, 2, 2'b10);
                set_bsb(0, 0, 0, 1, 3, 2'b10);
                set_bsb(0, 0, 2, 1, 3, 2'b10);
                set_brb(1, 0, 1, 4, 2'b01);
                for (int r = 2; r < 5; r++) set_brb(r, 0, 1, 3, 2'b10);
                set_io(2, 0, 1, 2'b01);
                set_lb(0, 0, (id == 2) ? 4'b0110 : 4'b1000, (id == 6));
            end
            default: ;
        endcase
    endtask

    typedef struct {
        int   cfg;
        logic b0;
        logic b1;
        logic exp;
    } vec_t;

    vec_t vt [17];

    initial begin
        // undriven pads float high through the bench pull-ups
        vt[0]  = '{0, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{0, 1'b1, 1'b1, 1'b1};
        vt[2]  = '{1, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{2, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{2, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{2, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{2, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{3, 1'b0, 1'b0, 1'b0};
        vt[10] = '{3, 1'b1, 1'b0, 1'b1};
        vt[11] = '{3, 1'b0, 1'b1, 1'b1};
        vt[12] = '{3, 1'b1, 1'b1, 1'b1};
        vt[13] = '{4, 1'b1, 1'b0, 1'b0};
        vt[14] = '{7, 1'b1, 1'b0, 1'b0};
        vt[15] = '{5, 1'b0, 1'b0, 1'b1};
        vt[16] = '{5, 1'b1, 1'b0, 1'b1};

        rst_n   = 1'b1;
        bot_drv = '0;
        load_cfg(6);
        bot_drv = 5'b00011;
        #1 rst_n = 1'b0;
        #1 check("reset_state", {4'b0, top_p[0]}, 5'd0);
        repeat (2) @(posedge clk);
        #1 check("reset_clocked", {4'b0, top_p[0]}, 5'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("pre_first_edge", {4'b0, top_p[0]}, 5'd0);
        @(posedge clk);
        #1 check("sync_capture_11", {4'b0, top_p[0]}, 5'd1);
        @(negedge clk) bot_drv = 5'b00001;
        #1 check("sync_hold", {4'b0, top_p[0]}, 5'd1);
        @(posedge clk);
        #1 check("sync_capture_10", {4'b0, top_p[0]}, 5'd0);
        @(negedge clk) bot_drv = 5'b00011;
        @(posedge clk);
        #1 check("sync_recapture", {4'b0, top_p[0]}, 5'd1);
        #2 rst_n = 1'b0;
        #1 check("async_clear", {4'b0, top_p[0]}, 5'd0);
        @(posedge clk);
        #1 check("reset_holds", {4'b0, top_p[0]}, 5'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("released_wait", {4'b0, top_p[0]}, 5'd0);
        @(posedge clk);
        #1 check("after_release", {4'b0, top_p[0]}, 5'd1);

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            load_cfg(vt[k].cfg);
            bot_drv = {{3{vt[k].b1}}, vt[k].b1, vt[k].b0};
            #2 check($sformatf("vec%0d_top0", k), {4'b0, top_p[0]}, {4'b0, vt[k].exp});
            if (vt[k].cfg == 0) begin
                check($sformatf("vec%0d_top_all", k), top_p, 5'b11111);
                check($sformatf("vec%0d_left_all", k), left_p, 5'b11111);
                check($sformatf("vec%0d_right_all", k), right_p, 5'b11111);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
